// File: rtl/bit_decrementor_counter_4_pkg.sv
// Shared definitions for the loadable countdown unit.
// Holds the state encoding, default width and the NAND primitive.
package bit_decrementor_counter_4_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

endpackage

// File: rtl/bit_decrementor_counter_4_half_subtractor.sv
// NAND-only half subtractor: diff = a ^ b, bout = ~a & b.
// Ports: a, b (in); diff, bout (out).
module half_subtractor
    import bit_decrementor_counter_4_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    logic n_ab;
    logic n_a;
    logic n_b;
    logic inv_a;
    logic n_bor;

    // Four-NAND XOR
    assign n_ab  = nand2(a, b);
    assign n_a   = nand2(a, n_ab);
    assign n_b   = nand2(b, n_ab);
    assign diff  = nand2(n_a, n_b);

    // NOT a, then AND as NAND followed by NAND-inverter
    assign inv_a = nand2(a, a);
    assign n_bor = nand2(inv_a, b);
    assign bout  = nand2(n_bor, n_bor);

endmodule

// File: rtl/bit_decrementor_counter_4.sv
// Loadable countdown timer with a one-cycle done pulse.
// Ports: clk, rst_n, start, din, tick, abort -> count, busy, done, borrow.
module bit_decrementor_counter_4
    import bit_decrementor_counter_4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             tick,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             borrow
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] dec;
    logic [WIDTH:0]   bchain;

    // Ripple chain computing count_q - 1; borrow-in fixed at 1.
    assign bchain[0] = 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sub
        half_subtractor u_hs (
            .a    (count_q[gi]),
            .b    (bchain[gi]),
            .diff (dec[gi]),
            .bout (bchain[gi+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = din;
                    state_d = (din == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    count_d = dec;
                    // Reaching zero ends the run, so no wrap occurs.
                    if (dec == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count  = count_q;
    assign busy   = (state_q == COUNT) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign borrow = bchain[WIDTH];

endmodule

// File: tb/tb_bit_decrementor_counter_4.sv
// Bench for bit_decrementor_counter_4: table vectors, corner sequences,
// and random traffic against a behavioural countdown model.
module tb_bit_decrementor_counter_4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] din;
    logic       tick;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       borrow;

    int n_vec;
    int n_bad;

    // Model: remaining count plus "running" and "finishing" flags.
    int m_count;
    bit m_busy;
    bit m_done;

    typedef struct {
        logic       st;
        logic [3:0] d;
        logic       tk;
        logic       ab;
        logic [3:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl[$];

    bit_decrementor_counter_4 #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .tick   (tick),
        .abort  (abort),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0;
        m_busy  = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input logic st, input logic [3:0] d,
                              input logic tk, input logic ab);
        if (m_done) begin
            m_done  = 0;
            m_busy  = 0;
            m_count = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_count = int'(d);
                m_busy  = 1;
                m_done  = (d == 4'd0);
            end
        end else if (ab) begin
            m_busy = 0;
        end else if (tk) begin
            m_count = m_count - 1;
            if (m_count == 0) m_done = 1;
        end
    endtask

    task automatic cycle(input logic st, input logic [3:0] d,
                         input logic tk, input logic ab);
        start = st;
        din   = d;
        tick  = tk;
        abort = ab;
        @(posedge clk);
        model_step(st, d, tk, ab);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] ec,
                         input logic eb, input logic ed, input logic ebr);
        n_vec++;
        if (count !== ec || busy !== eb || done !== ed || borrow !== ebr) begin
            n_bad++;
            $display("FAIL %s: got count=%h busy=%b done=%b borrow=%b, want count=%h busy=%b done=%b borrow=%b",
                     nm, count, busy, done, borrow, ec, eb, ed, ebr);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, 4'(m_count), m_busy, m_done, (m_count == 0));
    endtask

    task automatic add(input logic st, input logic [3:0] d, input logic tk,
                       input logic ab, input logic [3:0] ec, input logic eb,
                       input logic ed);
        vec_t v;
        v.st = st; v.d = d; v.tk = tk; v.ab = ab;
        v.ec = ec; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Full countdown from A, then zero load, lost start, abort.
        add(1'b1, 4'hA, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++)
            add(1'b0, 4'h0, 1'b1, 1'b0, 4'(10 - k), 1'b1, (k == 10));
        add(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        add(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1'b1, 4'h3, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0);
        add(1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);

        rst_n = 1'b0;
        start = 1'b0;
        din   = 4'h0;
        tick  = 1'b0;
        abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'h0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].d, tbl[i].tk, tbl[i].ab);
            check($sformatf("tbl%0d", i), tbl[i].ec, tbl[i].eb,
                  tbl[i].ed, (tbl[i].ec == 4'h0));
        end

        // Async reset mid-count with count = 5.
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        check_model("rst_load5");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            check("rst_hold", 4'h0, 1'b0, 1'b0, 1'b1);
        end
        rst_n = 1'b1;
        tick  = 1'b0;

        // Gapped ticks from F, abort with tick when count hits C.
        cycle(1'b1, 4'hF, 1'b0, 1'b0);
        check_model("gap_load");
        for (int i = 0; i < 40; i++) begin
            if (m_count == 12) begin
                cycle(1'b0, 4'h0, 1'b1, 1'b1);
                check("gap_abort", 4'hC, 1'b0, 1'b0, 1'b0);
                break;
            end
            cycle(1'b0, 4'h0, (i % 2 == 1), 1'b0);
            check_model("gap_step");
        end
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("gap_idle", 4'hC, 1'b0, 1'b0, 1'b0);

        // Starts in COUNT and DONE are ignored.
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        check_model("ign_load2");
        cycle(1'b1, 4'h3, 1'b1, 1'b0);
        check_model("ign_cnt");
        cycle(1'b1, 4'h3, 1'b1, 1'b0);
        check_model("ign_done");
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        check_model("ign_lost");
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        check("ign_accept", 4'h3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check_model("ign_abort");

        // Sweep every start value with continuous ticks.
        for (int v = 1; v <= 15; v++) begin
            cycle(1'b1, 4'(v), 1'b0, 1'b0);
            check_model("sweep_load");
            for (int c = 0; c < 20 && m_busy; c++) begin
                cycle(1'b0, 4'h0, 1'b1, 1'b0);
                check_model("sweep_step");
            end
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_decrementor_counter_4.md
# bit_decrementor_counter_4

Loadable 4-bit countdown unit, the decrementing counterpart of the gate-level incrementor in the arithmetic library. The datapath is a ripple chain of NAND-built half subtractors with a constant borrow-in of 1. A small FSM loads a start value, decrements on each qualified `tick`, and signals completion with a one-cycle `done` pulse. It serves as a reusable delay and terminal-count timer for the lab sequential blocks.

## Interface
- `WIDTH`, default 4: counter and datapath width. Verification is required at 4 only.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  load `din` and begin a countdown. Honoured only in IDLE.
- `din`  in  WIDTH  start value.
- `tick`  in  1  decrement qualifier. Used only in COUNT.
- `abort`  in  1  cancel the countdown and return to IDLE. Used only in COUNT.
- `count`  out  WIDTH  current counter value (registered).
- `busy`  out  1  high in COUNT and DONE.
- `done`  out  1  high for exactly one cycle, in DONE.
- `borrow`  out  1  borrow-out of the decrement chain applied to `count`. Equals 1 exactly when `count == 0`; combinational from `count`.

## Operation
- States: IDLE, COUNT, DONE.
- Reset (asynchronous, `rst_n` = 0):
  - State goes to IDLE.
  - `count` = 0, `busy` = 0, `done` = 0, and therefore `borrow` = 1.
  - Reset asserted mid-countdown discards the run immediately. No `done` pulse is produced.
- IDLE:
  - With `start` = 1 and `din` != 0: `count` <= `din`, go to COUNT.
  - With `start` = 1 and `din` = 0: `count` <= 0, go straight to DONE.
  - Otherwise `count` holds.
- COUNT, priority order is `abort` > `tick`:
  - `abort` = 1: go to IDLE and hold `count` at its current value. No `done` pulse.
  - `tick` = 1 and `count` > 1: `count` <= `count` - 1.
  - `tick` = 1 and `count` = 1: `count` <= 0, go to DONE.
  - `tick` = 0: hold.
  - `start` is ignored.
- DONE: `done` = 1. The next edge unconditionally returns to IDLE; `start`, `tick` and `abort` are ignored. `count` stays 0.
- Arithmetic:
  - `count` - 1 is computed only by the half-subtractor chain, never by a behavioural `-` operator.
  - Wrap from 0 to all-ones never occurs, because the FSM leaves COUNT on reaching 0.
- Outputs `busy` and `done` are decoded from the registered state, so they are glitch-free.

## Timing
- `start` is sampled at edge 0.
  - `count` = `din` and `busy` = 1 are visible after edge 0.
- With `tick` held high from edge 1 onward, `din` = N:
  - `count` = 0 and `done` = 1 after edge N.
  - `busy` = 0 and `done` = 0 after edge N+1.
  - Total occupancy is N+1 cycles.
- With `din` = 0: `done` = 1 after edge 0, and IDLE after edge 1.
- Ticks with gaps stretch the latency one cycle per missing tick. The number of decrements is exact.
- `abort` sampled at edge k: `busy` = 0 after edge k.
- A `start` presented in DONE is lost. A new `start` is accepted at the earliest on the edge after `done` has fallen.

## Structure
- Shared package or header holds:
  - The state encoding: IDLE = 2'b00, COUNT = 2'b01, DONE = 2'b10.
  - The default `WIDTH`.
- Sub-module `half_subtractor` (`diff`, `bout`, inputs `a`, `b`):
  - `diff` = a XOR b, built from the NAND-based XOR in the gate library.
  - `bout` = (NOT a) AND b, built from the NAND NOT and AND gates.
- A generate loop chains `WIDTH` instances: `b` of stage 0 = 1, and each later stage takes the `bout` of the stage before it. The final `bout` is `borrow`.
- FSM and count register live in the top module.

## Test plan
- Reset check: assert `rst_n` = 0 mid-COUNT with `count` = 5. Required: `count` = 0, `busy` = 0, `done` = 0 and `borrow` = 1 immediately, with no `done` pulse at any point.
- Full countdown: `din` = 4'hA, `start` pulse, `tick` held high. Required: `count` steps A, 9, …, 1, 0; `done` pulses once after edge 10; `busy` falls after edge 11.
- Zero load: `din` = 0 with `start`. Required: `done` = 1 one cycle after `start` with `count` = 0, then IDLE on the next edge.
- Gapped ticks with abort: `din` = 4'hF, ticks on alternate cycles, `abort` raised when `count` = 4'hC. Required: IDLE, `count` holds at C, no `done`; a `tick` asserted together with `abort` must not decrement.
- Ignored starts: pulse `start` with `din` = 3 during COUNT and again during DONE. Required: neither changes `count` or state; a `start` after `done` falls loads 3.
- Datapath sweep: load every value 1..15 with continuous `tick`. Required: `borrow` = 1 only when `count` = 0, and each decrement equals the value minus 1.
